// File: rtl/axis_router.sv
// rtl/axis_router.sv - 1-to-2 AXI-Stream router with sticky TDEST route and registered skid outputs

module axis_router_fifo #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  push,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_valid;
    logic                  pop;

    // The head register drives the output directly; the skid register holds the second entry.
    assign pop  = out_valid && out_ready;
    assign full = skid_valid;

    // Two-entry storage; a push is never presented while full, so a full FIFO only drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (pop) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (out_valid) begin
            if (push && pop) begin
                out_data <= in_data;
            end else if (push) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end
    end

endmodule

module axis_router #(
    parameter int DATA_WIDTH   = 512,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] AXIS_IN_TDATA,
    input  logic                  AXIS_IN_TDEST,
    input  logic                  AXIS_IN_TVALID,
    output logic                  AXIS_IN_TREADY,
    output logic [DATA_WIDTH-1:0] AXIS_OUT1_TDATA,
    output logic                  AXIS_OUT1_TVALID,
    input  logic                  AXIS_OUT1_TREADY,
    output logic [DATA_WIDTH-1:0] AXIS_OUT2_TDATA,
    output logic                  AXIS_OUT2_TVALID,
    input  logic                  AXIS_OUT2_TREADY,
    output logic [1:0]            ROUTE
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    localparam logic [15:0] TIMEOUT = 16'(IDLE_TIMEOUT);

    state_t      state;
    logic        dest;
    logic [15:0] idle_cnt;
    logic [1:0]  route_q;
    logic        full1;
    logic        full2;
    logic        push1;
    logic        push2;

    // Ready depends only on registered state and FIFO occupancy, never on TVALID.
    assign AXIS_IN_TREADY = (state == S_ACTIVE) && !(dest ? full2 : full1);
    assign push1          = AXIS_IN_TVALID && AXIS_IN_TREADY && !dest;
    assign push2          = AXIS_IN_TVALID && AXIS_IN_TREADY && dest;
    assign ROUTE          = route_q;

    // Route FSM: latch TDEST when leaving IDLE, release after the idle counter reaches the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            dest     <= 1'b0;
            idle_cnt <= '0;
            route_q  <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (AXIS_IN_TVALID) begin
                        dest     <= AXIS_IN_TDEST;
                        route_q  <= AXIS_IN_TDEST ? 2'd2 : 2'd1;
                        idle_cnt <= '0;
                        state    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (AXIS_IN_TVALID) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TIMEOUT) begin
                        state   <= S_IDLE;
                        route_q <= 2'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    route_q <= 2'd0;
                end
            endcase
        end
    end

    axis_router_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (AXIS_IN_TDATA),
        .push      (push1),
        .full      (full1),
        .out_data  (AXIS_OUT1_TDATA),
        .out_valid (AXIS_OUT1_TVALID),
        .out_ready (AXIS_OUT1_TREADY)
    );

    axis_router_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo2 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (AXIS_IN_TDATA),
        .push      (push2),
        .full      (full2),
        .out_data  (AXIS_OUT2_TDATA),
        .out_valid (AXIS_OUT2_TVALID),
        .out_ready (AXIS_OUT2_TREADY)
    );

endmodule

// File: tb/tb_axis_router.sv
// tb/tb_axis_router.sv - directed and scoreboarded checks for axis_router

module tb_axis_router;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_dest;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [DW-1:0] out2_data;
    logic          out2_valid;
    logic          out2_ready;
    logic [1:0]    route;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_out1 = 0;
    int n_out2 = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic          m_active = 1'b0;
    logic          m_dest   = 1'b0;
    int            m_cnt    = 0;

    axis_router #(.DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_IN_TDATA    (in_data),
        .AXIS_IN_TDEST    (in_dest),
        .AXIS_IN_TVALID   (in_valid),
        .AXIS_IN_TREADY   (in_ready),
        .AXIS_OUT1_TDATA  (out1_data),
        .AXIS_OUT1_TVALID (out1_valid),
        .AXIS_OUT1_TREADY (out1_ready),
        .AXIS_OUT2_TDATA  (out2_data),
        .AXIS_OUT2_TVALID (out2_valid),
        .AXIS_OUT2_TREADY (out2_ready),
        .ROUTE            (route)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the handshake edge has passed.
    task automatic send_beat(input logic [DW-1:0] d, input logic dst);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dst;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) check("send_timeout", 64'(waited), 64'd0);
        step();
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Scoreboard sampled mid-cycle: values seen here are what the next rising edge will act on.
    always @(negedge clk) begin
        if (reset) begin
            q1.delete();
            q2.delete();
            m_active = 1'b0;
            m_dest   = 1'b0;
            m_cnt    = 0;
        end else begin
            check("route", 64'(route), m_active ? 64'({1'b0, m_dest} + 2'd1) : 64'd0);
            check("in_ready", 64'(in_ready),
                  64'(m_active && ((m_dest ? q2.size() : q1.size()) < 2)));
            check("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
            check("out2_valid", 64'(out2_valid), 64'(q2.size() != 0));
            if (out1_valid && q1.size() != 0) check("out1_data", 64'(out1_data), 64'(q1[0]));
            if (out2_valid && q2.size() != 0) check("out2_data", 64'(out2_data), 64'(q2[0]));
            if (out1_valid && out1_ready && q1.size() != 0) begin
                void'(q1.pop_front());
                n_out1++;
            end
            if (out2_valid && out2_ready && q2.size() != 0) begin
                void'(q2.pop_front());
                n_out2++;
            end
            if (in_valid && in_ready && m_active) begin
                if (m_dest) q2.push_back(in_data);
                else        q1.push_back(in_data);
            end
            if (!m_active) begin
                if (in_valid) begin
                    m_active = 1'b1;
                    m_dest   = in_dest;
                    m_cnt    = 0;
                end
            end else if (in_valid) begin
                m_cnt = 0;
            end else if (m_cnt == TO) begin
                m_active = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    end

    initial begin
        int c0;
        int acc;
        int b1;
        int b2;
        reset      = 1'b1;
        in_data    = '0;
        in_dest    = 1'b0;
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        repeat (3) step();
        check("rst_route", 64'(route), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out1_valid", 64'(out1_valid), 64'd0);
        check("rst_out2_valid", 64'(out2_valid), 64'd0);
        check("rst_out1_data", 64'(out1_data), 64'd0);
        reset = 1'b0;
        step();

        // Burst of 8 beats to OUT1 at full rate.
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        c0         = cyc;
        in_valid   = 1'b1;
        in_dest    = 1'b0;
        in_data    = 32'h01;
        step();
        check("route_out1", 64'(route), 64'd1);
        for (int i = 2; i <= 8; i++) begin
            if (i == 2) send_beat(32'h01, 1'b0);
            send_beat(DW'(i), 1'b0);
        end
        check("burst_cycles", 64'(cyc - c0), 64'd9);
        in_valid = 1'b0;
        repeat (3) step();
        check("out1_count", 64'(n_out1), 64'd8);
        check("out2_none", 64'(n_out2), 64'd0);

        // Release after TO+1 idle edges (three already elapsed above).
        step();
        check("route_held_4", 64'(route), 64'd1);
        step();
        check("route_released", 64'(route), 64'd0);

        // OUT2 with backpressure: only two beats fit.
        out2_ready = 1'b0;
        in_valid   = 1'b1;
        in_dest    = 1'b1;
        in_data    = 32'h21;
        step();
        check("route_out2", 64'(route), 64'd2);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = DW'(32'h21 + acc);
            if (in_ready) acc++;
            step();
        end
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        b2 = n_out2;
        out2_ready = 1'b1;
        for (int i = 2; i < 5; i++) send_beat(DW'(32'h21 + i), 1'b1);
        idle_cycles(5);
        check("bp_delivered", 64'(n_out2 - b2), 64'd5);
        check("bp_route_rel", 64'(route), 64'd0);

        // Four idle cycles then resume keeps the route and clears the counter.
        send_beat(32'h31, 1'b0);
        send_beat(32'h32, 1'b0);
        idle_cycles(4);
        check("route_4idle", 64'(route), 64'd1);
        send_beat(32'h33, 1'b0);
        check("route_resume", 64'(route), 64'd1);
        idle_cycles(4);
        check("route_cnt_clr", 64'(route), 64'd1);
        step();
        check("route_rel2", 64'(route), 64'd0);

        // TDEST toggling mid-burst is ignored.
        b1 = n_out1;
        b2 = n_out2;
        for (int i = 0; i < 6; i++) send_beat(DW'(32'h41 + i), i[0]);
        idle_cycles(5);
        check("toggle_out1", 64'(n_out1 - b1), 64'd6);
        check("toggle_out2", 64'(n_out2 - b2), 64'd0);
        check("toggle_rel", 64'(route), 64'd0);
        send_beat(32'h51, 1'b1);
        check("new_route_out2", 64'(route), 64'd2);
        send_beat(32'h52, 1'b1);
        idle_cycles(5);
        check("new_burst_out2", 64'(n_out2 - b2), 64'd2);

        // Asynchronous reset with two beats buffered in OUT1.
        out1_ready = 1'b0;
        send_beat(32'h61, 1'b0);
        send_beat(32'h62, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out1_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out1_valid", 64'(out1_valid), 64'd0);
        check("arst_route", 64'(route), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        step();
        reset      = 1'b0;
        out1_ready = 1'b1;
        b1         = n_out1;
        repeat (5) step();
        check("post_rst_quiet", 64'(out1_valid), 64'd0);
        check("post_rst_count", 64'(n_out1 - b1), 64'd0);

        // Random traffic checked by the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_dest    = $urandom_range(0, 1) != 0;
            in_data    = $urandom();
            out1_ready = $urandom_range(0, 3) != 0;
            out2_ready = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        repeat (10) step();
        check("drain_q1", 64'(q1.size()), 64'd0);
        check("drain_q2", 64'(q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
